// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and limits shared by the param_alu slice
package alu_pkg;
  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    sub_op = 3'b101,
    max_op = 3'b110,
    rsv_op = 3'b111
  } operation_t;
  typedef enum logic {IDLE, MUL} state_t;
  localparam int MAX_MUL_LAT = 16;
endpackage

// File: rtl/alu_mul_pipe.sv
// alu_mul_pipe: full-width product delayed so the top's result register is the last of MUL_LAT stages
module alu_mul_pipe #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p
);
  logic [2*WIDTH-1:0] prod;
  assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  if (MUL_LAT == 1) begin : g_comb
    assign p = prod;
  end else begin : g_pipe
    logic [2*WIDTH-1:0] d [MUL_LAT-1];
    always_ff @(posedge clk) begin
      d[0] <= prod;
      for (int i = 1; i < MUL_LAT - 1; i++) d[i] <= d[i-1];
    end
    assign p = d[MUL_LAT-2];
  end
endmodule

// File: rtl/param_alu.sv
// param_alu: parametrised ALU with start/done handshake and a multi-cycle multiply
module param_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*WIDTH-1:0]   result
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(MAX_MUL_LAT);
  if (MUL_LAT < 1 || MUL_LAT > MAX_MUL_LAT) begin : g_bad_lat
    $error("param_alu: MUL_LAT out of range 1..16");
  end
  operation_t opc;
  state_t state;
  logic [CW-1:0] cnt;
  logic [W2-1:0] mul_p, alu_res;
  assign opc = operation_t'(op);
  assign busy = (state == MUL);
  alu_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul (
    .clk(clk),
    .a(A),
    .b(B),
    .p(mul_p)
  );
  always_comb begin
    alu_res = (opc == add_op) ? W2'(A) + W2'(B) :
              (opc == and_op) ? W2'(A & B) :
              (opc == xor_op) ? W2'(A ^ B) :
              (opc == mul_op) ? mul_p :
              (opc == sub_op) ? {{WIDTH{A < B}}, A - B} :
              (opc == max_op) ? W2'((A > B) ? A : B) : '0;
  end
  // Operands are consumed at the accepting edge; the multiply pipe carries them thereafter
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (state == MUL) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state  <= IDLE;
          done   <= 1'b1;
          err    <= 1'b0;
          result <= mul_p;
        end
      end else if (start) begin
        if (opc == mul_op && MUL_LAT > 1) begin
          state <= MUL;
          cnt   <= CW'(MUL_LAT - 1);
        end else if (opc != no_op) begin
          done <= 1'b1;
          err  <= (opc == rsv_op);
          if (opc != rsv_op) result <= alu_res;
        end
      end
    end
  end
endmodule

// File: tb/tb_param_alu.sv
// tb_param_alu: directed checks of param_alu at WIDTH=8/MUL_LAT=3 and WIDTH=16/MUL_LAT=1
module tb_param_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start8 = 1'b0, start16 = 1'b0;
  logic [2:0] op8 = '0, op16 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic busy8, done8, err8, busy16, done16, err16;
  logic [15:0] res8;
  logic [31:0] res16;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_alu #(.WIDTH(8), .MUL_LAT(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .err(err8), .result(res8)
  );
  param_alu #(.WIDTH(16), .MUL_LAT(1)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .err(err16), .result(res16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
  endtask

  task automatic cmd16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1; op16 = o; a16 = a; b16 = b;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_err", 32'(err8), 0);
    chk("rst_result", 32'(res8), 0);
    chk("rst_result16", res16, 0);
    // add with carry into bit WIDTH
    cmd8(3'b001, 8'hFF, 8'h01); tick(); start8 = 1'b0;
    chk("add_done", 32'(done8), 1);
    chk("add_err", 32'(err8), 0);
    chk("add_result", 32'(res8), 32'h0100);
    tick();
    chk("add_done_pulse", 32'(done8), 0);
    // back-to-back sub then max
    cmd8(3'b101, 8'h03, 8'h05); tick();
    chk("sub_done", 32'(done8), 1);
    chk("sub_result", 32'(res8), 32'hFFFE);
    cmd8(3'b110, 8'h03, 8'h05); tick();
    chk("max_done", 32'(done8), 1);
    chk("max_result", 32'(res8), 32'h0005);
    cmd8(3'b010, 8'hF0, 8'h3C); tick();
    chk("and_result", 32'(res8), 32'h0030);
    cmd8(3'b011, 8'hF0, 8'h3C); tick(); start8 = 1'b0;
    chk("xor_result", 32'(res8), 32'h00CC);
    // mul with an add dropped while busy
    cmd8(3'b100, 8'hFF, 8'hFF); tick();
    chk("mul_busy1", 32'(busy8), 1);
    chk("mul_nodone1", 32'(done8), 0);
    cmd8(3'b001, 8'h01, 8'h01); a8 = 8'h01; tick(); start8 = 1'b0; a8 = 8'h00;
    chk("mul_busy2", 32'(busy8), 1);
    chk("mul_nodone2", 32'(done8), 0);
    tick();
    chk("mul_done", 32'(done8), 1);
    chk("mul_busy_drop", 32'(busy8), 0);
    chk("mul_result", 32'(res8), 32'hFE01);
    tick();
    chk("drop_nodone", 32'(done8), 0);
    chk("drop_result", 32'(res8), 32'hFE01);
    // mul accepted in the done cycle of the previous mul
    cmd8(3'b100, 8'h10, 8'h10); tick(); start8 = 1'b0;
    tick(); tick();
    chk("b2b_done1", 32'(done8), 1);
    chk("b2b_result1", 32'(res8), 32'h0100);
    cmd8(3'b100, 8'h03, 8'h03); tick(); start8 = 1'b0; a8 = 8'h77;
    chk("b2b_busy", 32'(busy8), 1);
    tick(); tick();
    chk("b2b_done2", 32'(done8), 1);
    chk("b2b_result2", 32'(res8), 32'h0009);
    // reserved opcode, then no_op
    cmd8(3'b111, 8'h12, 8'h34); tick();
    chk("rsv_done", 32'(done8), 1);
    chk("rsv_err", 32'(err8), 1);
    chk("rsv_result", 32'(res8), 32'h0009);
    cmd8(3'b000, 8'h12, 8'h34); tick(); start8 = 1'b0;
    chk("noop_nodone", 32'(done8), 0);
    chk("noop_result", 32'(res8), 32'h0009);
    // reset one cycle after a mul is accepted
    cmd8(3'b100, 8'h02, 8'h02); tick(); start8 = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rstmul_busy", 32'(busy8), 0);
    chk("rstmul_done", 32'(done8), 0);
    chk("rstmul_err", 32'(err8), 0);
    chk("rstmul_result", 32'(res8), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstmul_late_done", 32'(done8), 0);
    end
    // start together with reset is ignored
    cmd8(3'b001, 8'h01, 8'h02); reset = 1'b1; tick(); reset = 1'b0; start8 = 1'b0;
    tick();
    chk("rststart_nodone", 32'(done8), 0);
    chk("rststart_result", 32'(res8), 0);
    // MUL_LAT=1: alternating mul/xor every cycle
    cmd16(3'b100, 16'h1234, 16'h0010); tick();
    chk("m1_done_a", 32'(done16), 1);
    chk("m1_busy_a", 32'(busy16), 0);
    chk("m1_mul_a", res16, 32'h00012340);
    cmd16(3'b011, 16'h00FF, 16'h0F0F); tick();
    chk("m1_done_b", 32'(done16), 1);
    chk("m1_xor_b", res16, 32'h00000FF0);
    cmd16(3'b100, 16'hFFFF, 16'hFFFF); tick();
    chk("m1_done_c", 32'(done16), 1);
    chk("m1_busy_c", 32'(busy16), 0);
    chk("m1_mul_c", res16, 32'hFFFE0001);
    cmd16(3'b011, 16'hAAAA, 16'h5555); tick(); start16 = 1'b0;
    chk("m1_done_d", 32'(done16), 1);
    chk("m1_xor_d", res16, 32'h0000FFFF);
    tick();
    chk("m1_idle", 32'(done16), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
